// File: rtl/key_debounce_pulse_if.sv
// Signal bundle between the key debouncer and the datapath control logic that consumes
// its level and strobes.
interface key_debounce_pulse_if;
  logic       key_in;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  // master: the debouncer itself; slave: the consumer that also supplies the synced key.
  modport master (
    input  key_in,
    output key_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );

  modport slave (
    output key_in,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );
endinterface

// File: rtl/key_debounce_pulse.sv
// Key debouncer: filters bounce on a synchronized key, emits registered level, press/release
// strobes and a wrapping press counter. Define AUTO_REPEAT_EN to add hold-to-repeat presses.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic                   clk,
  input logic                   Reset,
  key_debounce_pulse_if.master  kif
);

  typedef enum logic [1:0] {
    StIdleUp,
    StWaitDown,
    StHeldDown,
    StWaitUp
  } state_e;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counter cannot represent.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gen_bad_cycles
    $error("key_debounce_pulse: cycle parameters must be >= 1");
  end
  if ((64'(DEBOUNCE_CYCLES - 1) >> CNT_W) != 64'd0) begin : gen_bad_width
    $error("key_debounce_pulse: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic pressed;
  assign pressed = kif.key_in ^ (ACTIVE_LOW != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q, count_d;

`ifdef AUTO_REPEAT_EN
  if ((64'(REPEAT_DELAY - 1) >> CNT_W) != 64'd0 ||
      (64'(REPEAT_PERIOD - 1) >> CNT_W) != 64'd0) begin : gen_bad_repeat_width
    $error("key_debounce_pulse: CNT_W too narrow for REPEAT_DELAY/REPEAT_PERIOD");
  end

  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  // Low on entry to StHeldDown; set once the first (longer) repeat interval has elapsed.
  logic repeated_q, repeated_d;
  logic [CNT_W-1:0] repeat_last;
  assign repeat_last = repeated_q ? PeriodLast : DelayLast;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
`ifdef AUTO_REPEAT_EN
    repeated_d = repeated_q;
`endif

    unique case (state_q)
      StIdleUp: begin
        if (pressed) begin
          state_d = StWaitDown;
          cnt_d   = '0;
        end
      end

      StWaitDown: begin
        if (!pressed) begin
          state_d = StIdleUp;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeldDown;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
          cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
          repeated_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHeldDown: begin
        if (!pressed) begin
          state_d = StWaitUp;
          cnt_d   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (cnt_q == repeat_last) begin
            press_d    = 1'b1;
            count_d    = count_q + 8'd1;
            cnt_d      = '0;
            repeated_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end

      StWaitUp: begin
        if (pressed) begin
          // Release bounce: back to held with no pulse; repeat timing restarts.
          state_d = StHeldDown;
          cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
          repeated_d = 1'b0;
`endif
        end else if (cnt_q == DebLast) begin
          state_d   = StIdleUp;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdleUp;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdleUp;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      repeated_q <= 1'b0;
    end else begin
      repeated_q <= repeated_d;
    end
  end
`endif

  assign kif.key_level     = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.press_count   = count_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed scenarios plus random bouncing, checked each cycle
// against a run-length reference model of the debounce rules.
module tb_key_debounce_pulse;

  localparam int unsigned Deb = 4;
  localparam int unsigned Dly = 8;
  localparam int unsigned Per = 3;

  logic clk   = 1'b0;
  logic Reset = 1'b1;

  key_debounce_pulse_if kif ();

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (8),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (Dly),
    .REPEAT_PERIOD  (Per)
  ) u_dut (
    .clk  (clk),
    .Reset(Reset),
    .kif  (kif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: m_run counts consecutive edges where the key disagrees with the
  // accepted level; Deb+1 such edges accept the new level. m_held counts held edges.
  bit         m_level;
  int         m_run;
  int         m_held;
  bit         m_press;
  bit         m_rel;
  logic [7:0] m_count;
  int         n_press;
  int         n_rel;

  task automatic model_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_held  = 0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_count = 8'd0;
  endtask

  task automatic model_edge(input logic key);
    bit p;
    p       = !key;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (p != m_level) begin
      m_run++;
      if (m_run == Deb + 1) begin
        m_level = p;
        m_run   = 0;
        m_held  = 0;
        if (p) begin
          m_press = 1'b1;
          m_count = m_count + 8'd1;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else if (m_run != 0) begin
      m_run  = 0;
      m_held = 0;
    end else if (m_level) begin
      m_held++;
`ifdef AUTO_REPEAT_EN
      if (m_held == Dly || (m_held > Dly && (m_held - Dly) % Per == 0)) begin
        m_press = 1'b1;
        m_count = m_count + 8'd1;
      end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " level"}, 32'(kif.key_level), 32'(m_level));
    chk({tag, " press"}, 32'(kif.press_pulse), 32'(m_press));
    chk({tag, " release"}, 32'(kif.release_pulse), 32'(m_rel));
    chk({tag, " count"}, 32'(kif.press_count), 32'(m_count));
    chk({tag, " exclusive"}, 32'(kif.press_pulse & kif.release_pulse), 32'd0);
  endtask

  task automatic step(input string tag, input logic key);
    kif.key_in = key;
    @(posedge clk);
    model_edge(key);
    #1;
    check_outs(tag);
    if (kif.press_pulse === 1'b1) n_press++;
    if (kif.release_pulse === 1'b1) n_rel++;
  endtask

  // Reset for a few cycles with the key released, then check the cleared outputs.
  task automatic do_reset(input string tag);
    kif.key_in = 1'b1;
    Reset      = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    check_outs(tag);
  endtask

  int first_i;
  int seg_len;
  logic seg_key;

  initial begin
    kif.key_in = 1'b1;
    model_reset();
    n_press = 0;
    n_rel   = 0;

    // Reset held for 10 cycles with the key released.
    repeat (10) @(posedge clk);
    #1;
    Reset = 1'b0;
    check_outs("t1 reset");
    chk("t1 level const", 32'(kif.key_level), 32'd0);
    chk("t1 count const", 32'(kif.press_count), 32'd0);

    // Clean press then clean release, with explicit latency checks.
    n_press = 0;
    first_i = -1;
    for (int i = 0; i < 12; i++) begin
      step("t2 press", 1'b0);
      if (kif.press_pulse === 1'b1 && first_i < 0) first_i = i;
    end
    chk("t2 press latency", 32'(first_i), 32'(Deb));
    chk("t2 press pulses", 32'(n_press), 32'd1);
    chk("t2 press count", 32'(kif.press_count), 32'd1);
    n_rel   = 0;
    first_i = -1;
    for (int i = 0; i < 12; i++) begin
      step("t2 release", 1'b1);
      if (kif.release_pulse === 1'b1 && first_i < 0) first_i = i;
    end
    chk("t2 release latency", 32'(first_i), 32'(Deb));
    chk("t2 release pulses", 32'(n_rel), 32'd1);
    chk("t2 level low", 32'(kif.key_level), 32'd0);

    // Press bounce: 0,0,1,0,0,1,0 then steady 0.
    begin
      logic [6:0] bounce;
      bounce  = 7'b0010010;
      n_press = 0;
      for (int i = 6; i >= 0; i--) step("t3 bounce", bounce[i]);
      chk("t3 no early press", 32'(n_press), 32'd0);
      repeat (8) step("t3 settle", 1'b0);
      chk("t3 one press", 32'(n_press), 32'd1);
      chk("t3 count", 32'(kif.press_count), 32'd2);
      repeat (8) step("t3 release", 1'b1);
    end

    // 256 clean presses wrap the counter back to zero.
    do_reset("t4 reset");
    n_press = 0;
    for (int i = 0; i < 256; i++) begin
      repeat (Deb + 2) step("t4 press", 1'b0);
      repeat (Deb + 2) step("t4 release", 1'b1);
    end
    chk("t4 pulses", 32'(n_press), 32'd256);
    chk("t4 wrap", 32'(kif.press_count), 32'd0);

    // Asynchronous reset mid-debounce (cnt=2), then mid-hold.
    do_reset("t5 reset");
    repeat (3) step("t5 debounce", 1'b0);
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check_outs("t5 async wait");
    repeat (2) @(posedge clk);
    #1;
    Reset   = 1'b0;
    n_press = 0;
    first_i = -1;
    for (int i = 0; i < 8; i++) begin
      step("t5 repress", 1'b0);
      if (kif.press_pulse === 1'b1 && first_i < 0) first_i = i;
    end
    chk("t5 repress latency", 32'(first_i), 32'(Deb));
    chk("t5 held level", 32'(kif.key_level), 32'd1);
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check_outs("t5 async hold");
    chk("t5 hold level cleared", 32'(kif.key_level), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    repeat (8) step("t5 after", 1'b0);
    repeat (8) step("t5 release", 1'b1);

    // Long hold: repeats only when the optional feature is built in.
    do_reset("t6 reset");
    n_press = 0;
    repeat (30) step("t6 hold", 1'b0);
`ifdef AUTO_REPEAT_EN
    chk("t6 hold pulses", 32'(n_press), 32'(2 + (29 - (Deb + Dly)) / Per));
`else
    chk("t6 hold pulses", 32'(n_press), 32'd1);
`endif
    n_press = 0;
    repeat (12) step("t6 release", 1'b1);
    chk("t6 no pulse after release", 32'(n_press), 32'd0);

    // Random bouncy key activity.
    do_reset("t7 reset");
    for (int s = 0; s < 150; s++) begin
      seg_key = 1'($urandom % 2);
      seg_len = (($urandom % 4) == 0) ? 1 : int'($urandom_range(2, 3 * Deb));
      repeat (seg_len) step("t7 random", seg_key);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Consumer end of the button input path. Takes a KEY/SW signal that a 2-flop synchronizer has already registered into the clk domain.
- Filters contact bounce and produces a clean debounced level plus single-cycle press and release strobes.
- Keeps a wrapping press counter.
- Drives control inputs such as Run and ClearA_LoadB of the lab datapath FSMs, so one physical press equals exactly one event.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be >= 1.
- CNT_W, 20, width of the internal cycle counter; must hold DEBOUNCE_CYCLES-1, and REPEAT_DELAY-1 and REPEAT_PERIOD-1 when the optional feature is enabled.
- ACTIVE_LOW, 1, 1 = pressed when key_in==0 (DE2 KEYs); 0 = pressed when key_in==1.
- REPEAT_DELAY, 25000000, hold time before the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, interval between subsequent auto-repeats (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock
- Reset  input  1  reset; asynchronous, active-high
- key_in  input  1  synchronized raw key level (already registered in the clk domain)
- key_level  output  1  debounced pressed state, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press (and on repeats)
- release_pulse  output  1  one-cycle strobe on accepted release
- press_count  output  8  number of press_pulse strobes, mod 256

Behaviour:
- Internal pressed signal p = key_in XOR ACTIVE_LOW.
- Reset, asynchronous and active-high, forces: state IDLE_UP, cnt=0, key_level=0, press_pulse=0, release_pulse=0, press_count=0.
  - Reset asserted mid-debounce or mid-hold aborts with no pulse.
  - After Reset deassertion, a key already held must still pass the full debounce before it is reported.
- All outputs are registered. press_pulse and release_pulse default to 0 every cycle unless set by a transition below.
- States and transitions, evaluated each posedge clk:
  - IDLE_UP: p=1 -> WAIT_DOWN, cnt<=0. Otherwise stay.
  - WAIT_DOWN:
    - p=0 -> IDLE_UP, cnt<=0 (bounce rejected, no output change).
    - p=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD_DOWN, key_level<=1, press_pulse<=1, press_count<=press_count+1, cnt<=0.
    - p=1 otherwise -> cnt<=cnt+1.
  - HELD_DOWN: p=0 -> WAIT_UP, cnt<=0. Otherwise stay (see optional feature).
  - WAIT_UP:
    - p=1 -> HELD_DOWN, cnt<=0 (bounce rejected; key_level stays 1, no pulse).
    - p=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_UP, key_level<=0, release_pulse<=1, cnt<=0.
    - p=0 otherwise -> cnt<=cnt+1.
- Latency: the first edge sampling p=1 is edge 0. key_level and press_pulse become visible after edge DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+1 edges total, provided p stays 1 throughout. Release is symmetric.
- A single glitch cycle of the opposite level anywhere in a WAIT state restarts qualification from that state's origin.
- press_pulse and release_pulse are never asserted in the same cycle. Each lasts exactly 1 cycle.
- press_count wraps 255 -> 0 with no flag.
- DEBOUNCE_CYCLES=1: a new level is accepted after a single stable sampling cycle in the WAIT state. No special casing.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In HELD_DOWN, cnt increments every cycle while p=1.
  - On reaching REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), assert press_pulse for 1 cycle, increment press_count, and reset cnt to 0. A 1-bit first_repeat flag, cleared on entry to HELD_DOWN, selects between the two thresholds.
  - key_level remains 1 throughout.
  - Leaving HELD_DOWN (p=0) cancels pending repeats.
- Not defined: HELD_DOWN holds cnt at 0. Exactly one press_pulse per accepted press. The REPEAT_* parameters are ignored and no repeat logic is synthesized.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
1. Reset with key_in=1 for 10 cycles, release Reset -> key_level=0, both pulses 0, press_count=0.
2. key_in 1->0 held steady -> press_pulse high for exactly 1 cycle after the 5th edge, key_level=1, press_count=1. Then key_in=1 steady -> release_pulse 1 cycle after 5 edges, key_level=0.
3. key_in bounce 0,0,1,0,0,1,0 then steady 0 -> no output until 4 stable cycles are accepted; exactly one press_pulse; press_count +1.
4. 256 clean press/release cycles from press_count=0 -> press_count=0 at the end; each press yields exactly one pulse.
5. Reset asserted asynchronously during WAIT_DOWN (cnt=2) while key_in stays 0 -> outputs 0 immediately. After release, press_pulse appears 5 edges later.
6. AUTO_REPEAT_EN defined, REPEAT_DELAY=8, REPEAT_PERIOD=3, key held 30 cycles -> press_pulse at acceptance, +8 cycles, then every 3 cycles; no pulses after the release is accepted.
